uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Receive path of the UART peripheral. Takes the raw serial pad input (srx_pad_i), synchronises it,
//  detects and validates start bits, majority-samples 8N1 frames and buffers received bytes in a
//  small FIFO. The core-side peripheral register logic drains bytes over a valid/ready handshake.
//  Framing errors and overruns are reported to that logic.
// PARAMETERS
//  CLKS_PER_BIT  32  clk cycles per serial bit; min 8, even. 160 ns bit at 5 ns clk.
//  FIFO_DEPTH    4   receive FIFO entries, power of 2, >=2
//  CNT_W         3   fifo_count_o width = log2(FIFO_DEPTH)+1
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  srx_pad_i     in   1      serial input, idle high, asynchronous to clk
//  rx_data_o     out  8      byte at FIFO head
//  rx_valid_o    out  1      FIFO non-empty
//  rx_ready_i    in   1      consumer accepts head when rx_valid_o & rx_ready_i
//  fifo_count_o  out  CNT_W  current FIFO occupancy
//  frame_err_o   out  1      1-cycle pulse: stop bit sampled low
//  overrun_o     out  1      sticky: byte dropped on full FIFO
//  ovr_clr_i     in   1      clears overrun_o
//  rx_busy_o     out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): sync flops=1, FSM=IDLE, FIFO empty, rx_data_o=0, rx_valid_o=0,
//    fifo_count_o=0, frame_err_o=0, overrun_o=0, rx_busy_o=0. Reset mid-frame aborts the frame.
//  Sync: 2-flop synchroniser on srx_pad_i -> rxs, plus delayed copy rxs_d for edge detection.
//  Bit counter bc counts 0..CLKS_PER_BIT-1 within each bit. H=CLKS_PER_BIT/2.
//    Votes sampled at bc=H-1,H,H+1; bit value = majority, decided at bc=H+1.
//  FSM:
//   IDLE : on rxs_d=1 & rxs=0 -> START, bc<=0.
//   START: at decision, if vote=1 -> IDLE (glitch, nothing reported).
//          Else wait to bc=CLKS_PER_BIT-1 -> DATA, bit index=0, bc<=0.
//   DATA : decide each bit, shift in LSB first. After bit 7 reaches bc=CLKS_PER_BIT-1 -> STOP.
//   STOP : at decision (bc=H+1) go IDLE in the same cycle.
//          vote=1 -> push byte. vote=0 -> frame_err_o pulses the next cycle; byte discarded.
//          Returning at mid-stop allows back-to-back frames with no idle gap.
//  FIFO: push registered; rx_valid_o/fifo_count_o update the cycle after push (2 cycles push->valid).
//   Pop when rx_valid_o & rx_ready_i; next entry or empty visible next cycle.
//   Push and pop in the same cycle: count unchanged, both succeed, including when full.
//   Push on full with no pop: byte dropped; overrun_o set next cycle.
//   ovr_clr_i clears overrun_o; if clear and a new set coincide, set wins.
//   Pointers wrap modulo FIFO_DEPTH. rx_data_o shows the head entry; don't-care when empty.
//  Latency: stop-bit mid-point to rx_valid_o = ~2 clk plus the synchroniser delay (2 clk).
// TESTING
//  1) CLKS_PER_BIT=32. Frame 0x61 (start, 1,0,0,0,0,1,1,0, stop), rx_ready_i=0
//     -> rx_valid_o=1, rx_data_o=0x61, fifo_count_o=1; no errors.
//  2) 0x61, 500 ns idle, then 0x67 (1,1,1,0,0,1,1,0)
//     -> both bytes popped in order 0x61, 0x67; count returns to 0.
//  3) Low glitch on idle line lasting 10 clk -> FSM back to IDLE, no push, no frame_err_o.
//  4) Frame 0xA5 with stop bit held low, then line high
//     -> one frame_err_o pulse, FIFO unchanged; next 0x3C frame received correctly.
//  5) Five frames 0x01..0x05 back-to-back, rx_ready_i=0
//     -> count=4, overrun_o=1, head=0x01; pop order 0x01..0x04; ovr_clr_i clears the flag.
//  6) rst_n low during DATA bit 4 of a frame -> all outputs at reset values;
//     the next complete frame is received correctly.
//     Single-clk noise pulse at bc=H on one data bit -> majority vote corrects it.

Source files
------------

// File: rtl/uart_rx_deframer_if.sv
// ----------------------------------------------------------------------------
// uart_rx_deframer_if
// Byte handshake between the UART receive deframer (master) and the
// peripheral register logic that drains it (slave).
//
// Handshake: rx_valid_o is high while a byte is presented on rx_data_o, and
// it stays high with rx_data_o stable until the byte is taken. A byte
// transfers on every rising clk edge where rx_valid_o & rx_ready_i are both
// high. rx_ready_i may be asserted at any time, whether or not rx_valid_o is
// high, and does not depend combinationally on rx_valid_o.
//
// Signals
//   rx_data_o   master->slave  8  byte at FIFO head
//   rx_valid_o  master->slave  1  FIFO non-empty
//   rx_ready_i  slave->master  1  consumer accepts head this cycle
// ----------------------------------------------------------------------------
interface uart_rx_deframer_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// ----------------------------------------------------------------------------
// uart_rx_deframer
// Receive path of the UART: synchronises the serial pad, detects and
// validates start bits, majority-samples 8N1 frames and buffers received
// bytes in a small FIFO drained over a valid/ready handshake.
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   srx_pad_i     in   1      serial input, idle high, asynchronous to clk
//   rx_if         master      rx_data_o / rx_valid_o / rx_ready_i handshake
//   fifo_count_o  out  CNT_W  current FIFO occupancy
//   frame_err_o   out  1      1-cycle pulse: stop bit sampled low
//   overrun_o     out  1      sticky: byte dropped on full FIFO
//   ovr_clr_i     in   1      clears overrun_o
//   rx_busy_o     out  1      FSM not in IDLE
//   state_dbg_o   out  2      current FSM state (IDLE=0 START=1 DATA=2 STOP=3)
// ----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srx_pad_i,
  uart_rx_deframer_if.master   rx_if,
  output logic [CNT_W-1:0]     fifo_count_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i,
  output logic                 rx_busy_o,
  output logic [1:0]           state_dbg_o
);

  localparam int BC_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [BC_W-1:0]  BC_V0    = BC_W'(H - 1);
  localparam logic [BC_W-1:0]  BC_V1    = BC_W'(H);
  localparam logic [BC_W-1:0]  BC_DEC   = BC_W'(H + 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Synchroniser and edge detector
  logic sync1_q, rxs_q, rxs_d_q;

  // Frame FSM
  state_e          state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic [7:0]      push_data_q, push_data_d;
  logic            frame_err_q, frame_err_d;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;

  logic decide, vote, pop, push_ok, fifo_full;

  // Third vote is the live synchronised sample taken in the decision cycle.
  assign decide = (bc_q == BC_DEC);
  assign vote   = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);

  always_comb begin
    state_d     = state_q;
    bc_d        = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
    v0_d        = v0_q;
    v1_d        = v1_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;

    if (bc_q == BC_V0) v0_d = rxs_q;
    if (bc_q == BC_V1) v1_d = rxs_q;

    case (state_q)
      S_IDLE: begin
        bc_d = '0;
        if (rxs_d_q && !rxs_q) state_d = S_START;
      end
      S_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (decide && vote) begin
          state_d = S_IDLE;
        end else if (bc_q == BC_LAST) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {vote, shift_q[7:1]};
        if (bc_q == BC_LAST) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a start bit immediately after is caught.
        if (decide) begin
          state_d = S_IDLE;
          if (vote) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: push_q is the registered push request from the FSM.
  assign fifo_full = (count_q == FULL_CNT);
  assign pop       = (count_q != '0) && rx_if.rx_ready_i;
  // A pop in the same cycle frees a slot, so push on full still succeeds.
  assign push_ok   = push_q && (!fifo_full || pop);

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

    // Set has priority over clear.
    if (push_q && !push_ok) overrun_d = 1'b1;
    else if (ovr_clr_i)     overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_d_q     <= 1'b1;
      state_q     <= S_IDLE;
      bc_q        <= '0;
      v0_q        <= 1'b1;
      v1_q        <= 1'b1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= srx_pad_i;
      rxs_q       <= sync1_q;
      rxs_d_q     <= rxs_q;
      state_q     <= state_d;
      bc_q        <= bc_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data_o  = mem_q[rd_ptr_q];
  assign rx_if.rx_valid_o = (count_q != '0);
  assign fifo_count_o     = count_q;
  assign frame_err_o      = frame_err_q;
  assign overrun_o        = overrun_q;
  assign rx_busy_o        = (state_q != S_IDLE);
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer: 5 ns clock, 32 clk per bit, 4-entry
// FIFO. Frames are driven on the pad from negedge-aligned driver tasks and
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int CPB   = 32;
  localparam int H     = CPB / 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #2.5 clk = ~clk;

  logic          srx_pad_i = 1'b1;
  logic          ovr_clr_i = 1'b0;
  logic [CW-1:0] fifo_count_o;
  logic          frame_err_o, overrun_o, rx_busy_o;
  logic [1:0]    state_dbg_o;

  uart_rx_deframer_if rx_if ();

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .srx_pad_i    (srx_pad_i),
    .rx_if        (rx_if.master),
    .fifo_count_o (fifo_count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .ovr_clr_i    (ovr_clr_i),
    .rx_busy_o    (rx_busy_o),
    .state_dbg_o  (state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;   // clock cycles with frame_err_o high
  logic [7:0] exp_q[$];

  always @(posedge clk) if (rst_n && frame_err_o) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    srx_pad_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // noise_bit >= 0 inverts that data bit for one clk, aimed at the centre vote.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int noise_bit);
    srx_pad_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CPB; c++) begin
        srx_pad_i = (i == noise_bit && c == H + 1) ? ~d[i] : d[i];
        @(negedge clk);
      end
    end
    srx_pad_i = stop;
    repeat (CPB) @(negedge clk);
    srx_pad_i = 1'b1;
  endtask

  task automatic pop_expect(input string tag);
    int w;
    logic [7:0] e;
    w = 0;
    while (!rx_if.rx_valid_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_valid"}, 32'(rx_if.rx_valid_o), 32'd1);
    check({tag, "_data"}, 32'(rx_if.rx_data_o), 32'(e));
    rx_if.rx_ready_i = 1'b1;
    @(negedge clk);
    rx_if.rx_ready_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int fe0;
    rx_if.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_valid", 32'(rx_if.rx_valid_o), 32'd0);
    check("rst_data",  32'(rx_if.rx_data_o),  32'd0);
    check("rst_count", 32'(fifo_count_o),     32'd0);
    check("rst_ferr",  32'(frame_err_o),      32'd0);
    check("rst_ovr",   32'(overrun_o),        32'd0);
    check("rst_busy",  32'(rx_busy_o),        32'd0);
    rst_n = 1'b1;
    idle(10);

    // 1) Single frame 0x61, consumer stalled
    send_byte(8'h61, 1'b1, -1);
    exp_q.push_back(8'h61);
    check("t1_valid", 32'(rx_if.rx_valid_o), 32'd1);
    check("t1_data",  32'(rx_if.rx_data_o),  32'h61);
    check("t1_count", 32'(fifo_count_o),     32'd1);
    check("t1_ferr",  32'(fe_cnt),           32'd0);
    check("t1_ovr",   32'(overrun_o),        32'd0);
    check("t1_busy",  32'(rx_busy_o),        32'd0);
    pop_expect("t1_pop");

    // 2) 0x61, 500 ns idle, 0x67; drain in order
    send_byte(8'h61, 1'b1, -1);
    exp_q.push_back(8'h61);
    idle(100);
    send_byte(8'h67, 1'b1, -1);
    exp_q.push_back(8'h67);
    check("t2_count2", 32'(fifo_count_o), 32'd2);
    pop_expect("t2_pop0");
    pop_expect("t2_pop1");
    check("t2_count0", 32'(fifo_count_o), 32'd0);
    check("t2_valid0", 32'(rx_if.rx_valid_o), 32'd0);

    // 3) 10 clk low glitch on idle line
    fe0 = fe_cnt;
    srx_pad_i = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_busy_in", 32'(rx_busy_o), 32'd1);
    repeat (2) @(negedge clk);
    idle(40);
    check("t3_busy_out", 32'(rx_busy_o),    32'd0);
    check("t3_count",    32'(fifo_count_o), 32'd0);
    check("t3_ferr",     32'(fe_cnt - fe0), 32'd0);

    // 4) 0xA5 with stop held low, then a good 0x3C
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, -1);
    idle(20);
    check("t4_ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("t4_count",      32'(fifo_count_o), 32'd0);
    send_byte(8'h3C, 1'b1, -1);
    exp_q.push_back(8'h3C);
    check("t4_count1", 32'(fifo_count_o), 32'd1);
    pop_expect("t4_pop");

    // 5) Five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, -1);
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    idle(4);
    check("t5_count", 32'(fifo_count_o),     32'd4);
    check("t5_ovr",   32'(overrun_o),        32'd1);
    check("t5_head",  32'(rx_if.rx_data_o),  32'h01);
    for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("t5_pop%0d", i));
    check("t5_empty",       32'(rx_if.rx_valid_o), 32'd0);
    check("t5_ovr_sticky",  32'(overrun_o),        32'd1);
    ovr_clr_i = 1'b1;
    @(negedge clk);
    ovr_clr_i = 1'b0;
    check("t5_ovr_clr", 32'(overrun_o), 32'd0);

    // 6) Reset during DATA bit 4 with a byte waiting in the FIFO
    send_byte(8'h11, 1'b1, -1);
    check("t6_pre_count", 32'(fifo_count_o), 32'd1);
    srx_pad_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      srx_pad_i = i[0];
      repeat (CPB) @(negedge clk);
    end
    srx_pad_i = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_busy_pre", 32'(state_dbg_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(rx_if.rx_valid_o), 32'd0);
    check("t6_data",  32'(rx_if.rx_data_o),  32'd0);
    check("t6_count", 32'(fifo_count_o),     32'd0);
    check("t6_busy",  32'(rx_busy_o),        32'd0);
    check("t6_ovr",   32'(overrun_o),        32'd0);
    check("t6_ferr",  32'(frame_err_o),      32'd0);
    srx_pad_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    // Next frame, with a one-clk noise pulse on bit 3 at the centre vote
    send_byte(8'h5A, 1'b1, 3);
    exp_q.push_back(8'h5A);
    check("t6_count1", 32'(fifo_count_o), 32'd1);
    pop_expect("t6_pop");
    check("t6_ferr_none", 32'(fe_cnt - fe0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
